// File: rtl/oam_dma_pkg.sv
`default_nettype none
// ============================================================================
// oam_dma_pkg
// Shared types and constants for the FF46 OAM DMA controller.
// Revision: 1.0
// ============================================================================
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2,
        FLUSH = 2'd3
    } dma_state_e;

    localparam logic [7:0] FF46_ADDR   = 8'h46;
    localparam logic [7:0] ECHO_MASK   = 8'hDF;
    localparam int         DEF_DMA_LEN = 160;

    // Pages E0..FF alias onto the C0..DF work RAM.
    function automatic logic [7:0] echo_map(input logic [7:0] page);
        return (page >= 8'hE0) ? (page & ECHO_MASK) : page;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_addr_gen.sv
`default_nettype none
// ============================================================================
// oam_dma_addr_gen
// Byte index counter, one-byte hold register and last-byte flag for OAM DMA.
// Revision: 1.0
// ============================================================================
module oam_dma_addr_gen
    import oam_dma_pkg::*;
#(
    parameter int DMA_LEN = DEF_DMA_LEN
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_capture,
    input  logic       i_restart,
    input  logic       i_drain,
    input  logic [7:0] i_src_data,
    output logic [7:0] o_idx,
    output logic       o_last,
    output logic [7:0] o_hold_data,
    output logic [7:0] o_hold_addr,
    output logic       o_pend
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic [7:0] r_idx;
    logic [7:0] r_hold_data;
    logic [7:0] r_hold_addr;
    logic       r_pend;
    logic       w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_idx       <= 8'h00;
            r_hold_data <= 8'h00;
            r_hold_addr <= 8'h00;
            r_pend      <= 1'b0;
        end else begin
            if (i_capture) begin
                r_hold_data <= i_src_data;
                r_hold_addr <= r_idx;
                r_pend      <= 1'b1;
            end else if (i_drain) begin
                r_pend      <= 1'b0;
            end
            // Saturate at the last byte so the source address never leaves the page window.
            if (i_restart) begin
                r_idx <= 8'h00;
            end else if (i_capture && !w_last) begin
                r_idx <= r_idx + 8'h01;
            end
        end
    end

    assign o_idx       = r_idx;
    assign o_last      = w_last;
    assign o_hold_data = r_hold_data;
    assign o_hold_addr = r_hold_addr;
    assign o_pend      = r_pend;

endmodule
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// oam_dma_ctrl
// FF46 OAM DMA sequencer and CPU/DMA bus arbitration.
// Optional macro OAM_DMA_CPU_BLOCK_EN enables the cpu_blocked output.
// Revision: 1.0
// ============================================================================
module oam_dma_ctrl
    import oam_dma_pkg::*;
#(
    parameter int DMA_LEN     = DEF_DMA_LEN,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        m_tick,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        ffxx,
    input  logic        hram_cs,
    input  logic [7:0]  src_data,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        dma_active,
    output logic [15:0] dma_a,
    output logic        dma_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        cpu_blocked
);

    localparam int                DCNT_W    = $clog2(START_DELAY + 1);
    localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(START_DELAY);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    dma_state_e        r_state;
    logic [7:0]        r_page;
    logic [7:0]        r_act_page;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_arm;
    logic              r_active;

    logic       w_ff46_wr;
    logic       w_busy;
    logic       w_dcnt_done;
    logic       w_capture;
    logic       w_drain;
    logic       w_restart;
    logic [7:0] w_idx;
    logic       w_last;
    logic [7:0] w_hold_data;
    logic [7:0] w_hold_addr;
    logic       w_pend;

    assign w_ff46_wr   = cpu_wr && ffxx && (a[7:0] == FF46_ADDR);
    assign w_busy      = (r_state == XFER) || (r_state == FLUSH);
    assign w_dcnt_done = (r_dcnt == DCNT_ONE);
    assign w_capture   = m_tick && (r_state == XFER);
    assign w_drain     = m_tick && (r_state == FLUSH);
    // A CPU write on the same m_tick restarts the countdown instead of letting it expire.
    assign w_restart   = m_tick && !w_ff46_wr && w_dcnt_done &&
                         ((r_state == DELAY) || (w_busy && r_arm));

    oam_dma_addr_gen #(
        .DMA_LEN (DMA_LEN)
    ) u_addr_gen (
        .clk         (clk),
        .nreset      (nreset),
        .i_capture   (w_capture),
        .i_restart   (w_restart),
        .i_drain     (w_drain),
        .i_src_data  (src_data),
        .o_idx       (w_idx),
        .o_last      (w_last),
        .o_hold_data (w_hold_data),
        .o_hold_addr (w_hold_addr),
        .o_pend      (w_pend)
    );

    // A write while busy arms a restart; the running copy continues until the countdown ends.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_page     <= 8'h00;
            r_act_page <= 8'h00;
            r_dcnt     <= '0;
            r_arm      <= 1'b0;
            r_active   <= 1'b0;
        end else if (w_ff46_wr) begin
            r_page <= d_in;
            r_dcnt <= DCNT_INIT;
            case (r_state)
                XFER: begin
                    r_arm <= 1'b1;
                    if (m_tick && w_last) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (m_tick) begin
                        r_state <= DELAY;
                        r_arm   <= 1'b0;
                    end else begin
                        r_arm   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DELAY;
                    r_arm   <= 1'b0;
                end
            endcase
        end else if (m_tick) begin
            case (r_state)
                DELAY: begin
                    if (w_dcnt_done) begin
                        r_state    <= XFER;
                        r_act_page <= echo_map(r_page);
                        r_active   <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt - DCNT_ONE;
                    end
                end
                XFER, FLUSH: begin
                    if (r_arm && w_dcnt_done) begin
                        r_state    <= XFER;
                        r_act_page <= echo_map(r_page);
                        r_arm      <= 1'b0;
                        r_active   <= 1'b1;
                    end else begin
                        if (r_arm) r_dcnt <= r_dcnt - DCNT_ONE;
                        if (r_state == XFER) begin
                            if (w_last) r_state <= FLUSH;
                        end else if (r_arm) begin
                            r_state <= DELAY;
                            r_arm   <= 1'b0;
                        end else begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign d_out      = r_page;
    assign d_oe       = cpu_rd && ffxx && (a[7:0] == FF46_ADDR);
    assign dma_active = r_active;
    assign dma_rd     = (r_state == XFER);
    assign dma_a      = {r_act_page, w_idx};
    assign oam_addr   = w_hold_addr;
    assign oam_wdata  = w_hold_data;
    assign oam_we     = m_tick && w_pend;

`ifdef OAM_DMA_CPU_BLOCK_EN
    logic w_unused;
    assign w_unused    = &{1'b0, a[15:8]};
    assign cpu_blocked = r_active && !hram_cs && !ffxx;
`else
    logic w_unused;
    assign w_unused    = &{1'b0, a[15:8], hram_cs};
    assign cpu_blocked = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// tb_oam_dma_ctrl
// Randomised scoreboard bench for oam_dma_ctrl against a byte-pipeline model.
// Revision: 1.0
// ============================================================================
module tb_oam_dma_ctrl;

    localparam int LEN = 160;
    localparam int SD  = 1;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        m_tick = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        ffxx = 1'b0;
    logic        hram_cs = 1'b0;
    logic [7:0]  src_data;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        dma_active;
    logic [15:0] dma_a;
    logic        dma_rd;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        cpu_blocked;

    logic [7:0]  mem [65536];
    assign src_data = mem[dma_a];

    always #5 clk = ~clk;

    oam_dma_ctrl #(.DMA_LEN(LEN), .START_DELAY(SD)) u_dut (
        .clk(clk), .nreset(nreset), .m_tick(m_tick), .a(a), .d_in(d_in),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .ffxx(ffxx), .hram_cs(hram_cs),
        .src_data(src_data), .d_out(d_out), .d_oe(d_oe), .dma_active(dma_active),
        .dma_a(dma_a), .dma_rd(dma_rd), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .oam_we(oam_we), .cpu_blocked(cpu_blocked)
    );

    int total = 0;
    int bad = 0;
    int n_writes = 0;
    int active_cycles = 0;

    // Reference model: a read of byte k in one M-cycle is written to OAM at the end of the next.
    int         m_rd_k = -1;
    logic [7:0] m_rd_page = 8'h00;
    int         m_pend_k = -1;
    logic [7:0] m_pend_data = 8'h00;
    int         m_arm = 0;
    bit         m_active = 1'b0;
    logic [7:0] m_page = 8'h00;
    logic [7:0] m_oam [LEN];
    logic [7:0] d_oam [LEN];
    logic [15:0] exp_q [$];

    function automatic logic [7:0] eff_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_tick(input bit wr, input logic [7:0] wd);
        bit prev;
        prev = m_active;
        if (m_pend_k >= 0) begin
            exp_q.push_back({8'(m_pend_k), m_pend_data});
            m_oam[m_pend_k] = m_pend_data;
        end
        if (m_rd_k >= 0) begin
            m_pend_k    = m_rd_k;
            m_pend_data = mem[{m_rd_page, 8'(m_rd_k)}];
            m_rd_k      = (m_rd_k == LEN - 1) ? -1 : m_rd_k + 1;
        end else begin
            m_pend_k = -1;
        end
        if (wr) begin
            m_page = wd;
            m_arm  = SD;
        end else if (m_arm > 0) begin
            m_arm--;
            if (m_arm == 0) begin
                m_rd_k    = 0;
                m_rd_page = eff_page(m_page);
            end
        end
        m_active = (m_rd_k >= 0) || (m_pend_k >= 0) || ((m_arm > 0) && prev);
    endtask

    task automatic random_bus();
        int s;
        s = $urandom_range(0, 7);
        case (s)
            0: a = 16'hC000;
            1: a = 16'hFF80;
            2: a = 16'hFF0F;
            3: a = 16'hFF47;
            4: a = 16'hC046;
            5: a = 16'hFF46;
            6: a = 16'h8046;
            default: a = 16'hFFFE;
        endcase
        ffxx    = (a[15:8] == 8'hFF);
        hram_cs = (a >= 16'hFF80) && (a <= 16'hFFFE);
        cpu_rd  = 1'($urandom_range(0, 1));
        cpu_wr  = (!cpu_rd && a != 16'hFF46) ? 1'($urandom_range(0, 1)) : 1'b0;
        d_in    = 8'($urandom);
    endtask

    task automatic drive_ff46_wr(input logic [7:0] wd);
        a = 16'hFF46; ffxx = 1'b1; hram_cs = 1'b0;
        cpu_wr = 1'b1; cpu_rd = 1'b0; d_in = wd;
    endtask

    task automatic mcycle(input bit wr_idle, input bit wr_tick,
                          input logic [7:0] wd, input logic [7:0] wd2);
        int   n;
        logic exp_doe;
        logic exp_blk;
        n = $urandom_range(0, 2);
        if (wr_idle && n == 0) n = 1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (wr_idle && i == 0) begin
                drive_ff46_wr(wd);
                m_page = wd;
                m_arm  = SD;
            end else begin
                random_bus();
            end
        end
        @(posedge clk); #1;
        m_tick = 1'b1;
        if (wr_tick) drive_ff46_wr(wd2); else random_bus();
        #1;
        check("dma_active", dma_active, m_active);
        check("dma_rd", dma_rd, m_rd_k >= 0);
        if (m_rd_k >= 0) check("dma_a", dma_a, {m_rd_page, 8'(m_rd_k)});
        exp_doe = cpu_rd && ffxx && (a[7:0] == 8'h46);
        check("d_oe", d_oe, exp_doe);
        if (exp_doe) check("d_out", d_out, m_page);
`ifdef OAM_DMA_CPU_BLOCK_EN
        exp_blk = m_active && !hram_cs && !ffxx;
`else
        exp_blk = 1'b0;
`endif
        check("cpu_blocked", cpu_blocked, exp_blk);
        if (dma_active) active_cycles++;
        model_tick(wr_tick, wd2);
        @(posedge clk); #1;
        m_tick = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic run_to_idle(output int cyc);
        cyc = 0;
        while (!(m_rd_k < 0 && m_pend_k < 0 && m_arm == 0) && cyc < 400) begin
            mcycle(1'b0, 1'b0, 8'h00, 8'h00);
            cyc++;
        end
        if (cyc >= 400) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=%0d required<400", cyc);
        end
    endtask

    task automatic run_until(input bit use_rd, input int k);
        int g;
        g = 0;
        while (((use_rd ? m_rd_k : m_pend_k) != k) && g < 400) begin
            mcycle(1'b0, 1'b0, 8'h00, 8'h00);
            g++;
        end
        if (g >= 400) begin
            total++; bad++;
            $display("FAIL byte_wait_timeout actual=%0d required<400", g);
        end
    endtask

    task automatic check_oam_mem(input string name, input logic [15:0] base);
        for (int k = 0; k < LEN; k++) check(name, d_oam[k], mem[base + 16'(k)]);
    endtask

    task automatic check_oam_model(input string name);
        for (int k = 0; k < LEN; k++) check(name, d_oam[k], m_oam[k]);
    endtask

    always @(negedge clk) begin
        if (nreset && oam_we) begin
            n_writes++;
            if (oam_addr < 8'(LEN)) d_oam[oam_addr] = oam_wdata;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_oam_we actual=%h:%h required=none", oam_addr, oam_wdata);
            end else begin
                check("oam_write", {oam_addr, oam_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int         cyc;
        int         ac0;
        int         w0;
        int         kind;
        logic [7:0] p;
        logic [7:0] q;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < LEN; k++) begin
            m_oam[k] = 8'h00;
            d_oam[k] = 8'h00;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_oam_we", oam_we, 1'b0);
        check("rst_dma_rd", dma_rd, 1'b0);
        check("rst_dma_a", dma_a, 16'h0000);
        check("rst_d_out", d_out, 8'h00);
        check("rst_oam_addr", oam_addr, 8'h00);
        check("rst_cpu_blocked", cpu_blocked, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) mcycle(1'b0, 1'b0, 8'h00, 8'h00);

        // Plain transfer from C1xx
        ac0 = active_cycles; w0 = n_writes;
        mcycle(1'b1, 1'b0, 8'hC1, 8'h00);
        run_to_idle(cyc);
        check("s1_active_mcycles", active_cycles - ac0, 161);
        check("s1_write_count", n_writes - w0, 160);
        check_oam_mem("s1_oam", 16'hC100);

        // Echo page E3 reads C3xx
        mcycle(1'b1, 1'b0, 8'hE3, 8'h00);
        run_to_idle(cyc);
        check_oam_mem("s2_oam", 16'hC300);
        @(posedge clk); #1;
        a = 16'hFF46; ffxx = 1'b1; hram_cs = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0;
        #1;
        check("s2_readback_oe", d_oe, 1'b1);
        check("s2_readback", d_out, 8'hE3);
        @(posedge clk); #1;
        cpu_rd = 1'b0;

        // Restart mid-transfer: 80xx then 90xx, no gap in dma_active
        ac0 = active_cycles;
        mcycle(1'b1, 1'b0, 8'h80, 8'h00);
        repeat (50) mcycle(1'b0, 1'b0, 8'h00, 8'h00);
        mcycle(1'b1, 1'b0, 8'h90, 8'h00);
        run_to_idle(cyc);
        check("s3_active_no_gap", active_cycles - ac0, 51 + cyc);
        check_oam_mem("s3_oam", 16'h9000);

        // FF46 write coincident with the m_tick that writes byte 159
        p = 8'($urandom); q = 8'($urandom);
        mcycle(1'b1, 1'b0, p, 8'h00);
        run_until(1'b0, LEN - 1);
        mcycle(1'b0, 1'b1, 8'h00, q);
        check("s6_last_byte", d_oam[LEN-1], mem[{eff_page(p), 8'(LEN - 1)}]);
        run_to_idle(cyc);
        check_oam_mem("s6_oam", {eff_page(q), 8'h00});

        // Same, coincident with the tick ending the last source read
        p = 8'($urandom); q = 8'($urandom);
        mcycle(1'b1, 1'b0, p, 8'h00);
        run_until(1'b1, LEN - 1);
        mcycle(1'b0, 1'b1, 8'h00, q);
        run_to_idle(cyc);
        check_oam_model("s6b_oam");

        // Randomised starts, restarts and double writes during the delay
        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom); q = 8'($urandom);
            kind = $urandom_range(0, 3);
            mcycle(1'b1, kind == 3, p, q);
            if (kind == 1 || kind == 2) begin
                repeat ($urandom_range(0, 170)) mcycle(1'b0, 1'b0, 8'h00, 8'h00);
                mcycle(kind == 1, kind == 2, q, q);
            end
            run_to_idle(cyc);
            check_oam_model("rand_oam");
        end
        check("queue_drained", exp_q.size(), 0);

        // Asynchronous reset while a byte write is on the bus
        mcycle(1'b1, 1'b0, 8'hC5, 8'h00);
        run_until(1'b0, 20);
        @(posedge clk); #1;
        m_tick = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
        a = 16'hC000; ffxx = 1'b0; hram_cs = 1'b0;
        #1;
        check("s4_pre_oam_we", oam_we, 1'b1);
        nreset = 1'b0;
        #1;
        check("s4_oam_we", oam_we, 1'b0);
        check("s4_dma_active", dma_active, 1'b0);
        check("s4_dma_rd", dma_rd, 1'b0);
        check("s4_d_out", d_out, 8'h00);
        check("s4_cpu_blocked", cpu_blocked, 1'b0);
        m_rd_k = -1; m_pend_k = -1; m_arm = 0; m_active = 1'b0; m_page = 8'h00;
        exp_q.delete();
        @(posedge clk); #1;
        m_tick = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        w0 = n_writes;
        repeat (5) mcycle(1'b0, 1'b0, 8'h00, 8'h00);
        check("s4_no_writes", n_writes - w0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
